// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer: fetches 17-bit instructions, latches ALU operands,
// waits one settle cycle for an external combinational ALU, then writes back.
module alu_sequencer #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [16:0]       imem_data,
    output logic [2:0]        alu_opcode,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    input  logic [7:0]        alu_result,
    input  logic [7:0]        alu_carry,
    output logic              busy,
    output logic              halted,
    output logic              carry_flag,
    input  logic [1:0]        dbg_sel,
    output logic [7:0]        dbg_data
);

    // state  | meaning
    // IDLE   | after reset, waiting for start
    // FETCH  | imem_req high until imem_valid, ir captures the word
    // DECODE | halt check, ALU operands and opcode latched
    // EXEC   | settle cycle for the combinational ALU
    // WB     | write r[rd] and carry, advance pc
    // HALT   | halt word decoded, waiting for start
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [16:0]       ir_q, ir_d;
    logic [3:0][7:0]   r_q, r_d;
    logic [7:0]        alu_a_q, alu_a_d;
    logic [7:0]        alu_b_q, alu_b_d;
    logic [2:0]        alu_op_q, alu_op_d;
    logic              carry_q, carry_d;

    logic              ir_halt;
    logic [2:0]        ir_op;
    logic [1:0]        ir_rd, ir_rs, ir_rt;
    logic              ir_imm_sel;
    logic [7:0]        ir_imm;
    logic              unused_carry;

    assign ir_halt    = ir_q[16];
    assign ir_op      = ir_q[15:13];
    assign ir_rd      = ir_q[12:11];
    assign ir_rs      = ir_q[10:9];
    assign ir_imm_sel = ir_q[8];
    assign ir_imm     = ir_q[7:0];
    assign ir_rt      = ir_q[1:0];

    // only bit 0 of the carry vector is architecturally visible
    assign unused_carry = ^alu_carry[7:1];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        r_d      = r_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        carry_d  = carry_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (ir_halt) begin
                    state_d = S_HALT;
                end else begin
                    // operands captured here so rd==rs/rt cannot race the write-back
                    alu_a_d  = r_q[ir_rs];
                    alu_b_d  = ir_imm_sel ? ir_imm : r_q[ir_rt];
                    alu_op_d = ir_op;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                r_d[ir_rd] = alu_result;
                carry_d    = alu_carry[0];
                pc_d       = pc_q + ADDR_W'(1);
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            r_q      <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            r_q      <= r_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            carry_q  <= carry_d;
        end
    end

    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign alu_opcode = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign busy       = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                        (state_q == S_EXEC)  || (state_q == S_WB);
    assign halted     = (state_q == S_HALT);
    assign carry_flag = carry_q;
    assign dbg_data   = r_q[dbg_sel];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: small ALU model and instruction memory,
// hand-computed register, carry, address and timing expectations.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        imem_req;
    logic [3:0]  imem_addr;
    logic        imem_valid;
    logic [16:0] imem_data;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_a, alu_b, alu_result, alu_carry;
    logic        busy, halted, carry_flag;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    logic [16:0] imem [16];
    logic        valid_en;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_cyc;

    always #5 clk = ~clk;

    alu_sequencer #(.ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .busy(busy), .halted(halted), .carry_flag(carry_flag),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    assign imem_data  = imem[imem_addr];
    assign imem_valid = valid_en;

    // ALU model: 0 add (carry out), 1 sub, 2 and, 3 or, 4 xor, 5 pass b, else pass a
    always_comb begin
        logic [8:0] sum;
        sum        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry  = 8'h00;
        alu_result = alu_a;
        case (alu_opcode)
            3'd0: begin alu_result = sum[7:0]; alu_carry = {7'b0, sum[8]}; end
            3'd1: alu_result = alu_a - alu_b;
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = alu_a ^ alu_b;
            3'd5: alu_result = alu_b;
            default: alu_result = alu_a;
        endcase
    end

    function automatic logic [16:0] enc(input logic h, input logic [2:0] op,
                                        input logic [1:0] rd, input logic [1:0] rs,
                                        input logic sel, input logic [7:0] imm);
        return {h, op, rd, rs, sel, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
        dbg_sel = idx;
        #1;
        check(tag, {24'h0, dbg_data}, {24'h0, exp});
    endtask

    // pulse start, confirm fetch begins at address 0, then wait (bounded) for halt
    task automatic run_to_halt(output int cycles);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("fetch_from_0", {27'h0, imem_req, imem_addr}, {27'h0, 1'b1, 4'h0});
        cycles = 0;
        while (!halted && cycles < 300) begin
            tick();
            cycles++;
        end
        check("reached_halt", {31'h0, halted}, 32'h1);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; valid_en = 1'b1; dbg_sel = 2'd0;
        for (int i = 0; i < 16; i++) imem[i] = enc(1'b1, 3'd0, 2'd0, 2'd0, 1'b0, 8'h00);
        tick(); tick();
        check("rst_busy",   {31'h0, busy}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        check("rst_req",    {31'h0, imem_req}, 32'h0);
        check("rst_carry",  {31'h0, carry_flag}, 32'h0);
        check_reg("rst_r1", 2'd1, 8'h00);
        rst = 1'b1;
        tick();

        // program A: r1 = r0 + 5, then halt
        imem[0] = enc(1'b0, 3'd0, 2'd1, 2'd0, 1'b1, 8'h05);
        imem[1] = enc(1'b1, 3'd0, 2'd0, 2'd0, 1'b0, 8'h00);
        run_to_halt(n_cyc);
        // 4 cycles for the add, then FETCH and DECODE of the halt word
        check("a_halt_latency", n_cyc, 6);
        check_reg("a_r1", 2'd1, 8'h05);
        check("a_pc_at_halt", {28'h0, imem_addr}, 32'h1);
        check("a_carry", {31'h0, carry_flag}, 32'h0);

        // program B from HALT: r1 = 0xF0, r2 = r1 + 0x20 -> 0x10 carry 1
        imem[0] = enc(1'b0, 3'd5, 2'd1, 2'd0, 1'b1, 8'hF0);
        imem[1] = enc(1'b0, 3'd0, 2'd2, 2'd1, 1'b1, 8'h20);
        imem[2] = enc(1'b1, 3'd0, 2'd0, 2'd0, 1'b0, 8'h00);
        run_to_halt(n_cyc);
        check_reg("b_r1", 2'd1, 8'hF0);
        check_reg("b_r2", 2'd2, 8'h10);
        check("b_carry", {31'h0, carry_flag}, 32'h1);

        // program C: register operands and rd==rs==rt
        imem[0] = enc(1'b0, 3'd1, 2'd3, 2'd2, 1'b0, 8'h01);  // r3 = 0x10 - 0xF0 = 0x20
        imem[1] = enc(1'b0, 3'd0, 2'd1, 2'd1, 1'b0, 8'h01);  // r1 = 0xF0 + 0xF0 = 0xE0, c=1
        imem[2] = enc(1'b0, 3'd2, 2'd0, 2'd1, 1'b1, 8'h3C);  // r0 = 0xE0 & 0x3C = 0x20, c=0
        imem[3] = enc(1'b1, 3'd0, 2'd0, 2'd0, 1'b0, 8'h00);
        run_to_halt(n_cyc);
        check_reg("c_r3", 2'd3, 8'h20);
        check_reg("c_r1", 2'd1, 8'hE0);
        check_reg("c_r0", 2'd0, 8'h20);
        check_reg("c_r2_kept", 2'd2, 8'h10);
        check("c_carry", {31'h0, carry_flag}, 32'h0);

        // wait states: valid low for 3 FETCH cycles, start pulses while busy
        imem[0] = enc(1'b0, 3'd4, 2'd2, 2'd3, 1'b1, 8'hFF);  // r2 = 0x20 ^ 0xFF = 0xDF
        imem[1] = enc(1'b1, 3'd0, 2'd0, 2'd0, 1'b0, 8'h00);
        valid_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("w_fetch_req", {31'h0, imem_req}, 32'h1);
            check("w_fetch_addr", {28'h0, imem_addr}, 32'h0);
            valid_en = (i == 3);
            start = (i == 1);
            tick();
            start = 1'b0;
        end
        check("w_decode_req", {31'h0, imem_req}, 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("w_next_addr", {27'h0, imem_req, imem_addr}, {27'h0, 1'b1, 4'h1});
        check_reg("w_r2", 2'd2, 8'hDF);
        n_cyc = 0;
        while (!halted && n_cyc < 50) begin tick(); n_cyc++; end
        check("w_halted", {31'h0, halted}, 32'h1);

        // 16 increments of r0: pc wraps from 15 back to 0
        for (int i = 0; i < 16; i++) imem[i] = enc(1'b0, 3'd0, 2'd0, 2'd0, 1'b1, 8'h01);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 60; i++) tick();
        check("wrap_addr15", {27'h0, imem_req, imem_addr}, {27'h0, 1'b1, 4'hF});
        for (int i = 0; i < 4; i++) tick();
        check("wrap_addr0", {27'h0, imem_req, imem_addr}, {27'h0, 1'b1, 4'h0});
        check_reg("wrap_r0", 2'd0, 8'h30);

        // reset while in EXEC of the next increment
        tick();
        tick();
        check("pre_rst_alu_a", {24'h0, alu_a}, 32'h30);
        rst = 1'b0;
        start = 1'b1;
        tick();
        check("exec_rst_busy", {31'h0, busy}, 32'h0);
        check("exec_rst_req", {31'h0, imem_req}, 32'h0);
        check("exec_rst_alu", {13'h0, alu_opcode, alu_a, alu_b}, 32'h0);
        check("exec_rst_addr", {28'h0, imem_addr}, 32'h0);
        check_reg("exec_rst_r0", 2'd0, 8'h00);
        tick();
        check("rst_hold_busy", {31'h0, busy}, 32'h0);
        start = 1'b0;
        rst = 1'b1;
        tick();
        check("post_rst_idle", {30'h0, busy, halted}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
